// File: rtl/spi_txn_controller.sv
// spi_txn_controller
//   Frame sequencer for the serial configuration port. The first byte of a
//   frame is a command (bit7 = read, bits6:0 = start address). Each following
//   byte either writes the register bank at an auto-incrementing address or,
//   for reads, acknowledges one consumed slot and triggers the next read-back.
//
// Ports
//   iclk, rst          : clock, async active-high reset
//   byte_in/byte_valid : deserialized byte + single-cycle strobe
//   frame_end          : end-of-frame pulse, aborts any pending operation
//   rd_data            : bank read data, valid one cycle after reg_re
//   reg_addr/wdata/we/re : register bank access
//   tx_byte/tx_load    : next byte for the POCI serializer
//   busy, err          : not-IDLE flag, sticky error flag
//   frame_bytes        : bytes accepted this frame (saturating)
module spi_txn_controller #(
  parameter int NUM_REGS = 64
) (
  input  logic       iclk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       frame_end,
  input  logic [7:0] rd_data,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic       busy,
  output logic       err,
  output logic [7:0] frame_bytes
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_REQ, S_RD_CAP, S_RD_HOLD
  } state_t;

  localparam logic [7:0] NREGS = 8'(NUM_REGS);

  state_t     state_q, state_d;
  logic [6:0] ptr_q, ptr_d;          // address of the current/next access
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic [7:0] fb_q, fb_d;

  logic [6:0] ptr_inc;
  logic [7:0] fb_inc;

  function automatic logic in_range(input logic [6:0] a);
    return ({1'b0, a} < NREGS);
  endfunction

  assign ptr_inc = ptr_q + 7'd1;     // wraps 127 -> 0
  assign fb_inc  = (fb_q == 8'hFF) ? fb_q : fb_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    tx_byte_d   = tx_byte_q;
    tx_load_d   = 1'b0;
    err_d       = err_q;
    fb_d        = fb_q;

    // frame_end outranks everything, including a coincident byte.
    if (frame_end) begin
      state_d = S_IDLE;
      fb_d    = 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: if (byte_valid) begin
          ptr_d = byte_in[6:0];
          fb_d  = 8'd1;
          if (byte_in[7]) begin
            state_d    = S_RD_REQ;
            reg_addr_d = byte_in[6:0];
            reg_re_d   = in_range(byte_in[6:0]);
            if (!in_range(byte_in[6:0])) err_d = 1'b1;
          end else begin
            state_d = S_WRITE;
          end
        end
        S_WRITE: if (byte_valid) begin
          reg_addr_d  = ptr_q;
          reg_wdata_d = byte_in;
          reg_we_d    = in_range(ptr_q);
          if (!in_range(ptr_q)) err_d = 1'b1;
          ptr_d = ptr_inc;
          fb_d  = fb_inc;
        end
        S_RD_REQ: begin
          if (byte_valid) err_d = 1'b1;   // overrun: byte dropped
          state_d = S_RD_CAP;
        end
        S_RD_CAP: begin
          if (byte_valid) err_d = 1'b1;   // overrun: byte dropped
          // out-of-range reads still return a slot, filled with zero
          tx_byte_d = in_range(ptr_q) ? rd_data : 8'h00;
          tx_load_d = 1'b1;
          state_d   = S_RD_HOLD;
        end
        S_RD_HOLD: if (byte_valid) begin
          ptr_d      = ptr_inc;
          reg_addr_d = ptr_inc;
          reg_re_d   = in_range(ptr_inc);
          if (!in_range(ptr_inc)) err_d = 1'b1;
          fb_d    = fb_inc;
          state_d = S_RD_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 7'd0;
      reg_addr_q  <= 7'd0;
      reg_wdata_q <= 8'd0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      tx_byte_q   <= 8'd0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      fb_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      tx_byte_q   <= tx_byte_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      fb_q        <= fb_d;
    end
  end

  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_we      = reg_we_q;
  assign reg_re      = reg_re_q;
  assign tx_byte     = tx_byte_q;
  assign tx_load     = tx_load_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign frame_bytes = fb_q;

endmodule

// File: doc/spi_txn_controller.md
# spi_txn_controller

Transaction sequencer for the serial configuration port, running entirely on the internal clock `iclk`. It consumes deserialized bytes from the serial front end and interprets the first byte of each frame as a command (read/write flag plus start address). It then drives the on-chip register bank with auto-incrementing write or read strobes, and loads read-back bytes into the POCI serializer.

## Interface
- `NUM_REGS`, default 64: number of implemented registers. Valid addresses are 0 .. NUM_REGS-1. Legal range is 1..128.
- `iclk`  in  1: internal clock; the only clock. All logic is rising-edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `byte_in`  in  8: received byte, valid only while `byte_valid`=1.
- `byte_valid`  in  1: single-cycle pulse, already synchronized to `iclk`.
- `frame_end`  in  1: single-cycle pulse marking the end of a frame (serial clock stopped).
- `rd_data`  in  8: register bank read data, valid exactly one cycle after `reg_re`.
- `reg_addr`  out  7: register address.
- `reg_wdata`  out  8: write data.
- `reg_we`  out  1: write strobe, one cycle per write.
- `reg_re`  out  1: read strobe, one cycle per read.
- `tx_byte`  out  8: next byte for the POCI serializer.
- `tx_load`  out  1: one-cycle pulse; `tx_byte` is valid in the same cycle.
- `busy`  out  1: high in any state other than IDLE.
- `err`  out  1: sticky error flag; cleared only by `rst`.
- `frame_bytes`  out  8: bytes accepted in the current frame, including the command byte. Saturates at 255.

## Operation
- Command byte layout: bit7 = 1 for read, 0 for write. bits6:0 = start address.
- States and transitions:
  - IDLE: on `byte_valid`, latch the address, set `frame_bytes`=1, go to WRITE (bit7=0) or RD_REQ (bit7=1).
  - WRITE: on each `byte_valid`, perform one write at the current address, then increment the address.
  - RD_REQ: assert `reg_re` for one cycle; go to RD_CAP.
  - RD_CAP: capture `rd_data`; go to RD_HOLD.
  - RD_HOLD: on `byte_valid` (the host has consumed one slot), increment the address and go to RD_REQ. The content of that byte is ignored.
- Every accepted byte increments `frame_bytes`, with saturation at 255.
- Address increment is 7-bit and wraps from 127 to 0.
- Out-of-range address (address >= NUM_REGS):
  - Write: `reg_we` is suppressed and `err` is set.
  - Read: `reg_re` is suppressed and `err` is set. `tx_byte`=0x00 is still loaded with normal latency.
- Overrun: a `byte_valid` arriving in RD_REQ or RD_CAP is dropped, not counted, and sets `err`.
- `frame_end` in any state:
  - Return to IDLE on the next edge and clear `frame_bytes` to 0.
  - A pending read is abandoned and its `tx_load` is suppressed.
  - `err` is not cleared.
- If `frame_end` and `byte_valid` occur in the same cycle, `frame_end` wins and the byte is dropped without setting `err`.
- `frame_end` while in IDLE has no effect other than holding `frame_bytes` at 0.

## Timing
- Reset values: state IDLE, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `tx_byte`=0, `tx_load`=0, `busy`=0, `err`=0, `frame_bytes`=0.
- All outputs are registered.
- Write latency: data byte `byte_valid` in cycle M gives `reg_we`=1 with `reg_addr` and `reg_wdata` in cycle M+1. Back-to-back `byte_valid` every cycle is sustained with no loss.
- Read latency: command or slot `byte_valid` in cycle N gives:
  - `reg_re` in N+1,
  - `rd_data` sampled in N+2,
  - `tx_load` with `tx_byte` in N+3.
- The minimum `byte_valid` spacing during a read is 3 cycles; closer spacing is an overrun.
- `reg_we`, `reg_re` and `tx_load` are never high for more than one cycle per operation.
- `reg_addr` holds its last value between strobes.
- `busy` rises one cycle after the command byte and falls one cycle after `frame_end`.
- Asserting `rst` mid-operation forces all reset values immediately. A strobe in flight at that moment is cut.

## Test plan
- Write burst:
  - Stimulus: bytes 0x05, 0xAA, 0xBB, 0xCC, then `frame_end`.
  - Required: `reg_we` pulses at addresses 5, 6, 7 with data AA, BB, CC; `frame_bytes`=4 before `frame_end`; `err`=0; `busy`=0 afterwards.
- Read burst:
  - Stimulus: bank holds 0x11 at address 3 and 0x22 at address 4. Send command 0x83, then one slot byte at least 3 cycles later.
  - Required: `tx_byte`=0x11 on `tx_load` at N+3; `tx_byte`=0x22 at 3 cycles after the slot byte.
- Out-of-range and wrap, with NUM_REGS=64:
  - Stimulus: write command 0x3F followed by data bytes 0x01, 0x02.
  - Required: `reg_we` at address 63 only; `err`=1.
  - Stimulus: with NUM_REGS=128, write command 0x7F followed by data bytes 0x01, 0x02.
  - Required: writes at address 127 then address 0.
- Read out of range:
  - Stimulus: command 0xC8 (address 72, NUM_REGS=64).
  - Required: no `reg_re`; `tx_load` with `tx_byte`=0x00 at N+3; `err`=1.
- Overrun:
  - Stimulus: read command followed by a slot byte 1 cycle later.
  - Required: byte dropped; `frame_bytes` stays 1; `err`=1; normal `tx_load` at N+3.
- Frame end and reset:
  - Stimulus: `frame_end` in the RD_CAP cycle.
  - Required: no `tx_load`; IDLE; `frame_bytes`=0.
  - Stimulus: `frame_end` coincident with a data `byte_valid`.
  - Required: no `reg_we`.
  - Stimulus: `rst` asserted during WRITE.
  - Required: all outputs at reset values.
